// File: rtl/ebpc_pkg.sv
// Shared EBPC stream parameters used by the zero run-length decoder.
package ebpc_pkg;
  localparam int unsigned DATA_W           = 8;
  localparam int unsigned LOG_MAX_ZRLE_LEN = 4;
  localparam int unsigned MAX_ZRLE_LEN     = 2 ** LOG_MAX_ZRLE_LEN;
  localparam int unsigned CNT_W            = 16;
  // Bits occupied by one zero-run symbol: marker '0' plus the length code.
  localparam int unsigned SYM_W            = 1 + LOG_MAX_ZRLE_LEN;
endpackage

// File: rtl/zrld.sv
// Zero run-length decoder: turns the packed MSB-first ZRLE word stream back into
// one zero/non-zero flag per cycle, with an explicit per-block flag count.
module zrld
  import ebpc_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [DATA_W-1:0] data_i,
  input  logic              last_i,
  input  logic              vld_i,
  output logic              rdy_o,
  input  logic [CNT_W-1:0]  num_flags_i,
  output logic              is_one_o,
  output logic              last_o,
  output logic              vld_o,
  input  logic              rdy_i,
  output logic              idle_o,
  output logic              err_o
);
  localparam int unsigned BufW   = 2 * DATA_W;
  localparam int unsigned AvailW = $clog2(BufW + 1);
  localparam int unsigned RunW   = LOG_MAX_ZRLE_LEN + 1;
  localparam logic [AvailW-1:0] AvailWord = AvailW'(DATA_W);
  localparam logic [AvailW-1:0] AvailSym  = AvailW'(SYM_W);

  if (DATA_W < SYM_W) begin : g_width_check
    $error("zrld: DATA_W must be able to hold one complete zero-run symbol");
  end

  typedef enum logic [1:0] {StIdle, StDecode, StRun, StDrain} state_e;

  state_e                      state_q, state_d;
  logic [BufW-1:0]             buf_q, buf_d;
  logic [AvailW-1:0]           avail_q, avail_d;
  logic [CNT_W-1:0]            flags_q, flags_d;
  logic [RunW-1:0]             run_q, run_d;
  logic                        last_seen_q, last_seen_d;
  logic                        err_q, err_d;

  logic                        in_dec_run, top_one, sym_ok, accept, fire, clear;
  logic [AvailW-1:0]           consumed;
  logic [LOG_MAX_ZRLE_LEN-1:0] code;

  always_comb begin
    in_dec_run = (state_q == StDecode) || (state_q == StRun);
    top_one    = (avail_q != '0) && buf_q[BufW-1];
    sym_ok     = !buf_q[BufW-1] && (avail_q >= AvailSym);
    code       = buf_q[BufW-2 -: LOG_MAX_ZRLE_LEN];
    rdy_o      = in_dec_run ? ((avail_q <= AvailWord) && !last_seen_q) : 1'b1;
    vld_o      = (state_q == StRun) || ((state_q == StDecode) && top_one);
    is_one_o   = (state_q == StDecode) && top_one;
    last_o     = vld_o && (flags_q == CNT_W'(1));
    idle_o     = (state_q == StIdle) && !vld_i;
    err_o      = err_q;
    accept     = vld_i && rdy_o;
    fire       = vld_o && rdy_i;
  end

  always_comb begin
    state_d     = state_q;
    buf_d       = buf_q;
    avail_d     = avail_q;
    flags_d     = flags_q;
    run_d       = run_q;
    last_seen_d = last_seen_q;
    err_d       = 1'b0;
    consumed    = '0;
    clear       = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (vld_i) begin
          buf_d       = {data_i, {DATA_W{1'b0}}};
          avail_d     = AvailWord;
          flags_d     = num_flags_i;
          last_seen_d = last_i;
          state_d     = StDecode;
          if (num_flags_i == '0) begin
            err_d   = 1'b1;
            clear   = 1'b1;
            state_d = last_i ? StIdle : StDrain;
          end
        end
      end
      StDecode: begin
        if (top_one) begin
          if (rdy_i) begin
            consumed = AvailW'(1);
            flags_d  = flags_q - CNT_W'(1);
          end
        end else if (sym_ok) begin
          // The symbol is swallowed without an output: one bubble per run.
          consumed = AvailSym;
          run_d    = RunW'(code) + RunW'(1);
          state_d  = StRun;
        end else if (last_seen_q) begin
          err_d   = 1'b1;
          clear   = 1'b1;
          state_d = StIdle;
        end
      end
      StRun: begin
        if (rdy_i) begin
          run_d   = run_q - RunW'(1);
          flags_d = flags_q - CNT_W'(1);
          if (run_q == RunW'(1)) state_d = StDecode;
        end
      end
      StDrain: begin
        if (vld_i && last_i) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // New word lands directly below the bits that survive this cycle's consumption.
    if (in_dec_run) begin
      buf_d   = buf_q << consumed;
      avail_d = avail_q - consumed;
      if (accept) begin
        buf_d       = buf_d | ({data_i, {DATA_W{1'b0}}} >> avail_d);
        avail_d     = avail_d + AvailWord;
        last_seen_d = last_i;
      end
    end

    if (fire && last_o) begin
      clear   = 1'b1;
      state_d = (last_seen_q || (accept && last_i)) ? StIdle : StDrain;
    end

    if (clear) begin
      buf_d       = '0;
      avail_d     = '0;
      flags_d     = '0;
      run_d       = '0;
      last_seen_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      buf_q       <= '0;
      avail_q     <= '0;
      flags_q     <= '0;
      run_q       <= '0;
      last_seen_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      buf_q       <= buf_d;
      avail_q     <= avail_d;
      flags_q     <= flags_d;
      run_q       <= run_d;
      last_seen_q <= last_seen_d;
      err_q       <= err_d;
    end
  end
endmodule

// File: tb/tb_zrld.sv
// Directed self-checking bench for zrld: hand-decoded ZRLE blocks, backpressure,
// drain, underflow and asynchronous reset.
module tb_zrld;
  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic [7:0]  data_i = '0;
  logic        last_i = 1'b0;
  logic        vld_i = 1'b0;
  logic        rdy_o;
  logic [15:0] num_flags_i = '0;
  logic        is_one_o;
  logic        last_o;
  logic        vld_o;
  logic        rdy_i = 1'b1;
  logic        idle_o;
  logic        err_o;

  int n_tests = 0;
  int n_fail = 0;
  int n_rdy_low;

  always #5 clk_i = ~clk_i;

  zrld u_dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .data_i      (data_i),
    .last_i      (last_i),
    .vld_i       (vld_i),
    .rdy_o       (rdy_o),
    .num_flags_i (num_flags_i),
    .is_one_o    (is_one_o),
    .last_o      (last_o),
    .vld_o       (vld_o),
    .rdy_i       (rdy_i),
    .idle_o      (idle_o),
    .err_o       (err_o)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drives up to two words (words[15:8] first) and checks every flag handshake
  // against exp (bit i = flag i). rdy_i is held low for stall_len cycles from stall_at.
  task automatic run_block(input string tag, input logic [15:0] words, input int nw,
                           input int w1_delay, input logic [15:0] nf,
                           input logic [31:0] exp, input int nexp,
                           input int stall_at, input int stall_len, input bit exp_err);
    int   wi = 0;
    int   fi = 0;
    int   cyc = 0;
    int   n_err = 0;
    int   tail = -1;
    bit   stall_prev = 1'b0;
    logic prev_vld = 1'b0;
    logic prev_one = 1'b0;
    n_rdy_low = 0;
    while (tail != 0 && cyc < 300) begin
      vld_i       = (wi < nw) && (wi == 0 || cyc >= w1_delay);
      data_i      = (wi == 0) ? words[15:8] : words[7:0];
      last_i      = (wi == nw - 1);
      num_flags_i = nf;
      rdy_i       = !(cyc >= stall_at && cyc < stall_at + stall_len);
      @(negedge clk_i);
      if (err_o) n_err++;
      if (!rdy_o) n_rdy_low++;
      if (stall_prev && !rdy_i) begin
        check({tag, "_stall_vld"}, vld_o, prev_vld);
        check({tag, "_stall_one"}, is_one_o, prev_one);
      end
      stall_prev = !rdy_i;
      prev_vld   = vld_o;
      prev_one   = is_one_o;
      if (vld_o && rdy_i) begin
        if (fi < nexp) begin
          check({tag, "_flag"}, is_one_o, exp[fi]);
          check({tag, "_last"}, last_o, (fi == nexp - 1) && !exp_err);
        end else begin
          check({tag, "_extra_flag"}, fi, nexp);
        end
        fi++;
      end
      if (tail > 0) tail--;
      else if (tail < 0 && wi == nw && idle_o) tail = 2;
      if (vld_i && rdy_o) wi++;
      @(posedge clk_i);
      #1;
      cyc++;
    end
    vld_i = 1'b0;
    rdy_i = 1'b1;
    check({tag, "_finished"}, tail == 0, 1'b1);
    check({tag, "_nflags"}, fi, nexp);
    check({tag, "_words"}, wi, nw);
    check({tag, "_err"}, n_err, exp_err);
    check({tag, "_idle"}, idle_o, 1'b1);
  endtask

  initial begin
    @(posedge clk_i);
    @(posedge clk_i);
    #1;
    check("rst_rdy", rdy_o, 1'b1);
    check("rst_idle", idle_o, 1'b1);
    check("rst_vld", vld_o, 1'b0);
    check("rst_last", last_o, 1'b0);
    check("rst_err", err_o, 1'b0);
    check("rst_one", is_one_o, 1'b0);
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;

    // 0x8A: '1' | '0 0010' (3 zeros) | '1' -> 1,0,0,0,1
    run_block("basic", 16'h8A00, 1, 0, 16'd5, 32'h11, 5, 999, 0, 1'b0);
    // 0x7C: '0 1111' (16 zeros) | '1'
    run_block("maxrun", 16'h7C00, 1, 0, 16'd17, 32'h1_0000, 17, 999, 0, 1'b0);
    // 0xE8,0x80: 1,1,1 | '0 1000' (9 zeros) | '1' from the second word
    run_block("cross", 16'hE880, 2, 0, 16'd13, 32'h1007, 13, 999, 0, 1'b0);
    check("cross_rdy_low", n_rdy_low != 0, 1'b1);
    // Stall three cycles in the middle of the zero run
    run_block("stall", 16'h8A00, 1, 0, 16'd5, 32'h11, 5, 3, 3, 1'b0);
    // Run clipped to the block length; trailing 0xFF discarded
    run_block("early", 16'h8AFF, 2, 0, 16'd2, 32'h1, 2, 999, 0, 1'b0);
    run_block("drain", 16'h8AFF, 2, 6, 16'd2, 32'h1, 2, 999, 0, 1'b0);
    // Stream runs dry after five flags
    run_block("under", 16'h8A00, 1, 0, 16'd20, 32'h11, 5, 999, 0, 1'b1);
    run_block("zero_nf", 16'h8A00, 1, 0, 16'd0, 32'h0, 0, 999, 0, 1'b1);

    // Asynchronous reset while emitting a zero run
    vld_i       = 1'b1;
    data_i      = 8'h7C;
    last_i      = 1'b1;
    num_flags_i = 16'd17;
    rdy_i       = 1'b1;
    @(posedge clk_i);
    #1;
    vld_i = 1'b0;
    @(posedge clk_i);
    #1;
    @(posedge clk_i);
    #1;
    check("pre_rst_vld", vld_o, 1'b1);
    check("pre_rst_one", is_one_o, 1'b0);
    rst_ni = 1'b0;
    #1;
    check("mid_rst_vld", vld_o, 1'b0);
    check("mid_rst_idle", idle_o, 1'b1);
    check("mid_rst_rdy", rdy_o, 1'b1);
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;
    run_block("post_rst", 16'h8A00, 1, 0, 16'd5, 32'h11, 5, 999, 0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
